// File: rtl/prefix_accumulate_if.sv
// Host memory port of the prefix_accumulate block.
//
// Carries the host-side single-port RAM access signals. The host is the
// master: it drives write enable, address and write data, and receives the
// RAM read data (which is valid one cycle after the address, whoever owns
// the RAM port at the time).
//
//   controlArrWEnable_a  host -> dut  1     write enable
//   controlArrAddr_a     host -> dut  AW    word address
//   controlArrWData_a    host -> dut  W     write data (signed)
//   controlArrRData_a    dut -> host  W     RAM read data (signed)
interface prefix_accumulate_if #(
   parameter int unsigned AW = 10,
   parameter int unsigned W  = 64
);
   logic          controlArrWEnable_a;
   logic [AW-1:0] controlArrAddr_a;
   logic [W-1:0]  controlArrWData_a;
   logic [W-1:0]  controlArrRData_a;

   modport master (
      output controlArrWEnable_a,
      output controlArrAddr_a,
      output controlArrWData_a,
      input  controlArrRData_a
   );

   modport slave (
      input  controlArrWEnable_a,
      input  controlArrAddr_a,
      input  controlArrWData_a,
      output controlArrRData_a
   );
endinterface

// File: rtl/prefix_accumulate.sv
// In-place running (prefix) sum engine over an internal single-port RAM.
//
// The host loads the array through the shared memory port while controlArr
// is high, pulses r_enable, waits for w_enable, then reads the results back
// through the same port. Each element costs two cycles: READ presents the
// address, ADD consumes the read data and writes the new accumulator back.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (RAM contents are kept)
//   r_enable    start strobe, accepted only in idle or done
//   controlArr  1 = host owns the RAM port, 0 = engine owns it
//   init_i      start index of the loop
//   init_acc    initial accumulator value (signed)
//   w_enable    done flag, held until the next accepted start or reset
//   result      completion status, tracks w_enable
//   host        host memory port (write enable, address, data, read data)
module prefix_accumulate #(
   parameter int unsigned N     = 1000,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned W     = 64,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         r_enable,
   input  logic         controlArr,
   input  logic [W-1:0] init_i,
   input  logic [W-1:0] init_acc,
   output logic         w_enable,
   output logic         result,
   prefix_accumulate_if.slave host
);

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StRead,
      StAdd,
      StDone
   } state_e;

   state_e        state_q;
   logic [W-1:0]  i_q;
   logic [W-1:0]  acc_q;

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  rdata_q;

   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [W-1:0]  ram_wdata;

   logic          eng_we;
   logic [AW-1:0] eng_addr;
   logic [W-1:0]  sum;
   logic [W-1:0]  i_next;

   // Engine always points the RAM at the current element; it only writes in
   // ADD, where the read data issued in the preceding READ is on rdata_q.
   assign eng_addr = i_q[AW-1:0];
   assign eng_we   = (state_q == StAdd);
   assign sum      = acc_q + rdata_q;
   assign i_next   = i_q + W'(1);

   // Port mux: the host wins whenever it holds controlArr, which also keeps
   // a stalled engine from writing.
   always_comb begin
      ram_we    = eng_we;
      ram_addr  = eng_addr;
      ram_wdata = sum;
      if (controlArr) begin
         ram_we    = host.controlArrWEnable_a;
         ram_addr  = host.controlArrAddr_a;
         ram_wdata = host.controlArrWData_a;
      end
   end

   // Single-port RAM, synchronous read; read-during-write returns old data.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      rdata_q <= mem[ram_addr];
   end

   assign host.controlArrRData_a = rdata_q;

   // Control FSM. While controlArr is high the engine holds; a stall seen in
   // ADD falls back to READ because rdata_q may now hold a host read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         i_q      <= '0;
         acc_q    <= '0;
         w_enable <= 1'b0;
         result   <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (r_enable) begin
                  i_q      <= init_i;
                  acc_q    <= init_acc;
                  w_enable <= 1'b0;
                  result   <= 1'b0;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               if (!controlArr) begin
                  if (i_q >= W'(N)) begin
                     w_enable <= 1'b1;
                     result   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     state_q <= StRead;
                  end
               end
            end
            StRead: begin
               if (!controlArr) begin
                  state_q <= StAdd;
               end
            end
            StAdd: begin
               if (controlArr) begin
                  state_q <= StRead;
               end else begin
                  acc_q <= sum;
                  i_q   <= i_next;
                  // Loop bound checked on the incremented index so the next
                  // element starts straight in READ.
                  if (i_next >= W'(N)) begin
                     w_enable <= 1'b1;
                     result   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     state_q <= StRead;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prefix_accumulate.sv
// Directed self-checking bench for prefix_accumulate.
module tb_prefix_accumulate;

   localparam int N = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_enable;
   logic        controlArr;
   logic [63:0] init_i;
   logic [63:0] init_acc;
   logic        w_enable;
   logic        result;

   prefix_accumulate_if #(.AW(10), .W(64)) mem_if ();

   prefix_accumulate dut (
      .clk        (clk),
      .rst        (rst),
      .r_enable   (r_enable),
      .controlArr (controlArr),
      .init_i     (init_i),
      .init_acc   (init_acc),
      .w_enable   (w_enable),
      .result     (result),
      .host       (mem_if)
   );

   always #5 clk = ~clk;

   logic [63:0] model [N];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic host_take();
      @(negedge clk);
      controlArr = 1'b1;
      mem_if.controlArrWEnable_a = 1'b0;
   endtask

   task automatic host_write(input int a, input logic [63:0] d);
      @(negedge clk);
      mem_if.controlArrWEnable_a = 1'b1;
      mem_if.controlArrAddr_a    = a[9:0];
      mem_if.controlArrWData_a   = d;
   endtask

   task automatic host_idle();
      @(negedge clk);
      mem_if.controlArrWEnable_a = 1'b0;
   endtask

   task automatic host_read(input int a, output logic [63:0] d);
      @(negedge clk);
      mem_if.controlArrWEnable_a = 1'b0;
      mem_if.controlArrAddr_a    = a[9:0];
      @(negedge clk);
      d = mem_if.controlArrRData_a;
   endtask

   task automatic readback(input string tag, input int lo, input int hi);
      logic [63:0] d;
      for (int k = lo; k <= hi; k++) begin
         host_read(k, d);
         check($sformatf("%s[%0d]", tag, k), d, model[k]);
      end
   endtask

   // Reference prefix sum, 64-bit wrap-around.
   task automatic model_run(input logic [63:0] ii, input logic [63:0] aa);
      logic [63:0] acc;
      acc = aa;
      if (ii < 64'(N)) begin
         for (int k = int'(ii); k < N; k++) begin
            acc      = acc + model[k];
            model[k] = acc;
         end
      end
   endtask

   task automatic start_run(input logic [63:0] ii, input logic [63:0] aa);
      @(negedge clk);
      controlArr = 1'b0;
      mem_if.controlArrWEnable_a = 1'b0;
      init_i   = ii;
      init_acc = aa;
      r_enable = 1'b1;
      @(negedge clk);
      r_enable = 1'b0;
   endtask

   // Latency counted in clock edges after the edge that sampled r_enable.
   task automatic wait_done(input int budget, output int lat);
      lat = 0;
      while (!w_enable && lat <= budget) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [63:0] d;
      int unsigned v;

      rst        = 1'b1;
      r_enable   = 1'b0;
      controlArr = 1'b1;
      init_i     = '0;
      init_acc   = '0;
      mem_if.controlArrWEnable_a = 1'b0;
      mem_if.controlArrAddr_a    = '0;
      mem_if.controlArrWData_a   = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_w_enable", 64'(w_enable), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      rst = 1'b0;

      // Load and read back.
      for (int k = 0; k < N; k++) begin
         v        = $urandom_range(32'h7FFF_FFFF, 0);
         model[k] = 64'(v);
         host_write(k, model[k]);
      end
      host_idle();
      readback("load", 0, N - 1);

      // Full prefix sum from zero.
      model_run(64'd0, 64'd0);
      start_run(64'd0, 64'd0);
      wait_done(2100, lat);
      check("full_latency", 64'(lat), 64'd2001);
      check("full_result", 64'(result), 64'd1);
      repeat (20) @(negedge clk);
      check("done_hold", 64'(w_enable), 64'd1);
      host_take();
      readback("sum", 0, N - 1);
      check("done_hold_readback", 64'(w_enable), 64'd1);

      // Host stall mid-run with host reads, plus a start that must be ignored.
      model_run(64'd0, 64'd17);
      start_run(64'd0, 64'd17);
      repeat (101) @(negedge clk);
      controlArr = 1'b1;
      for (int k = 0; k < 5; k++) begin
         mem_if.controlArrAddr_a = 10'(k * 37 + 3);
         @(negedge clk);
      end
      controlArr = 1'b0;
      repeat (7) @(negedge clk);
      init_i   = 64'd500;
      init_acc = 64'd999;
      r_enable = 1'b1;
      @(negedge clk);
      r_enable = 1'b0;
      wait_done(2200, lat);
      check("stall_done", 64'(w_enable), 64'd1);
      host_take();
      readback("stall", 0, N - 1);

      // Offset start: all ones, init_i = 998, init_acc = 5.
      for (int k = 0; k < N; k++) begin
         model[k] = 64'd1;
         host_write(k, 64'd1);
      end
      host_idle();
      model_run(64'd998, 64'd5);
      start_run(64'd998, 64'd5);
      wait_done(50, lat);
      check("offset_latency", 64'(lat), 64'd5);
      host_take();
      host_read(998, d);
      check("offset_998", d, 64'd6);
      host_read(999, d);
      check("offset_999", d, 64'd7);
      readback("offset", 0, N - 1);

      // Signed overflow wraps.
      host_write(0, 64'h7FFF_FFFF_FFFF_FFFF);
      host_write(1, 64'd1);
      host_idle();
      model[0] = 64'h7FFF_FFFF_FFFF_FFFF;
      model[1] = 64'd1;
      model_run(64'd0, 64'd0);
      start_run(64'd0, 64'd0);
      wait_done(2100, lat);
      check("wrap_latency", 64'(lat), 64'd2001);
      host_take();
      host_read(0, d);
      check("wrap_0", d, 64'h7FFF_FFFF_FFFF_FFFF);
      host_read(1, d);
      check("wrap_1", d, 64'h8000_0000_0000_0000);
      readback("wrap", 2, 5);

      // Empty loops: no RAM change.
      start_run(64'd1000, 64'd3);
      wait_done(10, lat);
      check("empty_latency", 64'(lat), 64'd1);
      check("empty_result", 64'(result), 64'd1);
      start_run(64'hFFFF_FFFF_0000_0000, 64'd3);
      wait_done(10, lat);
      check("empty_big_latency", 64'(lat), 64'd1);
      host_take();
      readback("empty", 0, 3);
      readback("empty", 996, 999);

      // Reset mid-run, with r_enable on the same edge: reset wins.
      start_run(64'd0, 64'd0);
      repeat (50) @(negedge clk);
      rst      = 1'b1;
      r_enable = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      r_enable = 1'b0;
      check("midrst_w_enable", 64'(w_enable), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      repeat (2100) @(negedge clk);
      check("midrst_idle", 64'(w_enable), 64'd0);

      // Restart after reset still works (empty loop).
      start_run(64'd1000, 64'd0);
      wait_done(10, lat);
      check("restart_latency", 64'(lat), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/prefix_accumulate.md
Name: prefix_accumulate

Overview:
- Accelerator that computes an in-place running (prefix) sum over a 1000-entry array of signed 64-bit words, held in an internal single-port RAM.
- A host loads the array through a shared memory port, pulses a start strobe, waits for done, then reads the results back through the same port.
- The port-select input `controlArr` chooses whether the host or the internal engine owns the RAM.

Parameters:
- N, 1000: number of elements processed (loop bound, exclusive).
- DEPTH, 1024: RAM depth; address width = 10.
- W, 64: data width (signed two's complement).

Ports:
- clk  input  1  clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- r_enable  input  1  start strobe, one-cycle pulse.
- controlArr  input  1  1 = host owns the RAM port; 0 = engine owns it.
- init_i  input  64  start index of the loop (normally 0).
- init_acc  input  64  initial accumulator value (signed).
- w_enable  output  1  done flag.
- result  output  1  completion status.
- controlArrWEnable_a  input  1  host write enable.
- controlArrAddr_a  input  10  host address.
- controlArrWData_a  input  64  host write data (signed).
- controlArrRData_a  output  64  RAM read data (signed), valid for either owner.

Behaviour:
- Reset values:
  - State = IDLE.
  - w_enable = 0, result = 0.
  - Internal index and accumulator cleared to 0.
  - RAM contents are not reset.
- RAM:
  - Single port, synchronous read and write.
  - Read data appears on controlArrRData_a one cycle after the address is presented.
  - Write takes effect at the clock edge.
  - Read-during-write to the same address returns the old data.
- Port mux:
  - When controlArr = 1, the RAM address, write enable and write data come from the host `_a` inputs.
  - When controlArr = 0, they come from the engine.
  - controlArrRData_a always shows the RAM read output.
- Start:
  - In IDLE or DONE, r_enable = 1 latches i = init_i and acc = init_acc.
  - It clears w_enable and result, then enters RUN.
  - r_enable is ignored while the engine is busy.
- RUN loop, per element:
  - If i >= N (unsigned compare), go to DONE.
  - Otherwise READ: drive addr = i[9:0] with no write.
  - Next cycle, ADD: acc = acc + rdata (64-bit wrap-around, no saturation), then write the new acc to addr i[9:0] and set i = i + 1.
  - Cost is 2 cycles per element; total latency ≈ 2*(N − init_i) + 2 cycles from start to w_enable.
- Stall: while controlArr = 1 during RUN, the engine holds its state and issues no writes. When ownership returns, it re-issues the READ for the current i, so the result is unaffected by host reads.
- DONE:
  - w_enable = 1 and result = 1.
  - Both stay high until the next accepted start or reset, so the host may read back all results over many cycles while w_enable remains high.
- Boundaries:
  - init_i >= N: no RAM writes; DONE in ≤2 cycles after start.
  - r_enable asserted together with rst: reset wins.
  - rst asserted mid-run: return to IDLE immediately. Partially written RAM contents remain.

Test Plan:
- Load/readback:
  - With controlArr = 1, write addresses 0..999 with random values in [0, 2^31−1].
  - Reading address k then returns the written value on the next cycle.
- Prefix sum:
  - After the load, set controlArr = 0, init_i = 0, init_acc = 0, and pulse r_enable for 1 cycle.
  - w_enable rises after about 2002 cycles and stays high; result = 1.
  - With controlArr = 1, reading addr k gives sum of original[0..k] for all k = 0..999.
- Offsets:
  - Array all 1s, init_i = 998, init_acc = 5.
  - Expect addr 998 = 6, addr 999 = 7, addr 0..997 unchanged.
- Wrap-around:
  - arr[0] = 0x7FFF_FFFF_FFFF_FFFF, arr[1] = 1, init_acc = 0.
  - Expect arr[1] = 0x8000_0000_0000_0000 (negative as signed).
- Empty loop: init_i = 1000 -> w_enable = 1 within 2 cycles, no RAM change.
- Reset and stall:
  - Assert rst mid-run -> w_enable = 0 and the engine is idle.
  - Separately, toggle controlArr = 1 for 5 cycles mid-run -> final sums still correct.
